// File: rtl/fc_accumulator_if.sv
// rtl/fc_accumulator_if.sv - term/bias stream into the FC accumulator and per-neuron result out
interface fc_accumulator_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
);
  logic                     valid_i;
  logic signed [DATA_W-1:0] act_i;
  logic signed [DATA_W-1:0] weight_i;
  logic                     has_bias_i;
  logic signed [DATA_W-1:0] bias_i;
  logic                     relu_en_i;
  logic                     valid_o;
  logic signed [DATA_W-1:0] result_o;
  logic [IDX_W-1:0]         neuron_idx_o;
  logic                     sat_o;
  logic                     done_o;

  modport master (
    output valid_i, act_i, weight_i, has_bias_i, bias_i, relu_en_i,
    input  valid_o, result_o, neuron_idx_o, sat_o, done_o
  );

  modport slave (
    input  valid_i, act_i, weight_i, has_bias_i, bias_i, relu_en_i,
    output valid_o, result_o, neuron_idx_o, sat_o, done_o
  );
endinterface

// File: rtl/fc_accumulator.sv
// rtl/fc_accumulator.sv - two-stage fixed-point MAC with bias, ReLU and saturation per FC neuron
module fc_accumulator #(
  parameter int DATA_W  = 16,
  parameter int FRAC    = 8,
  parameter int ACC_W   = 40,
  parameter int FAN_IN  = 64,
  parameter int FAN_OUT = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               forward,
  fc_accumulator_if.slave    bus
);
  localparam int CNT_W = (FAN_IN > 1) ? $clog2(FAN_IN) : 1;
  localparam int IDX_W = (FAN_OUT > 1) ? $clog2(FAN_OUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FAN_IN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FAN_OUT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic                    prev_forward;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        nidx;
  logic signed [ACC_W-1:0] acc;

  logic                    s1_valid;
  logic signed [ACC_W-1:0] s1_p;
  logic                    s1_first;
  logic                    s1_last;
  logic                    s1_bias_add;
  logic signed [ACC_W-1:0] s1_bias;
  logic                    s1_relu;

  logic                      mode_switch;
  logic                      accept;
  logic                      first;
  logic                      last;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] prod_sh;
  logic signed [ACC_W-1:0]   base;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   rect;
  logic                      sat_hi;
  logic                      sat_lo;
  logic signed [DATA_W-1:0]  clipped;

  always_comb begin
    mode_switch = forward ^ prev_forward;
    accept      = bus.valid_i && forward && !mode_switch;
    first       = (cnt == '0);
    last        = (cnt == CNT_LAST);
    prod        = bus.act_i * bus.weight_i;
    // Arithmetic shift floors toward -inf, matching the Q-format truncation
    prod_sh     = prod >>> FRAC;
    base        = s1_first ? (s1_bias_add ? s1_bias : '0) : acc;
    sum         = base + s1_p;
    rect        = (s1_relu && sum[ACC_W-1]) ? '0 : sum;
    sat_hi      = (rect > SAT_MAX);
    sat_lo      = (rect < SAT_MIN);
    clipped     = sat_hi ? SAT_MAX[DATA_W-1:0] :
                  sat_lo ? SAT_MIN[DATA_W-1:0] : rect[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_forward     <= 1'b0;
      cnt              <= '0;
      nidx             <= '0;
      acc              <= '0;
      s1_valid         <= 1'b0;
      s1_p             <= '0;
      s1_first         <= 1'b0;
      s1_last          <= 1'b0;
      s1_bias_add      <= 1'b0;
      s1_bias          <= '0;
      s1_relu          <= 1'b0;
      bus.valid_o      <= 1'b0;
      bus.result_o     <= '0;
      bus.neuron_idx_o <= '0;
      bus.sat_o        <= 1'b0;
      bus.done_o       <= 1'b0;
    end else begin
      prev_forward <= forward;
      bus.valid_o  <= 1'b0;
      bus.sat_o    <= 1'b0;
      bus.done_o   <= 1'b0;
      if (mode_switch) begin
        // Flush everything in flight, including a completed neuron still in stage 1
        cnt      <= '0;
        nidx     <= '0;
        acc      <= '0;
        s1_valid <= 1'b0;
      end else begin
        s1_valid <= accept;
        if (accept) begin
          cnt         <= last ? '0 : cnt + CNT_W'(1);
          s1_p        <= ACC_W'(prod_sh);
          s1_first    <= first;
          s1_last     <= last;
          s1_bias_add <= first && bus.has_bias_i;
          s1_bias     <= ACC_W'(bus.bias_i);
          s1_relu     <= bus.relu_en_i;
        end
        if (s1_valid) begin
          acc <= sum;
          if (s1_last) begin
            bus.valid_o      <= 1'b1;
            bus.result_o     <= clipped;
            bus.sat_o        <= sat_hi || sat_lo;
            bus.neuron_idx_o <= nidx;
            bus.done_o       <= (nidx == IDX_LAST);
            nidx             <= (nidx == IDX_LAST) ? '0 : nidx + IDX_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fc_accumulator.sv
// tb/tb_fc_accumulator.sv - directed checks of the FC accumulator with FAN_IN=4, FAN_OUT=3
module tb_fc_accumulator;
  localparam int DATA_W  = 16;
  localparam int FRAC    = 8;
  localparam int ACC_W   = 40;
  localparam int FAN_IN  = 4;
  localparam int FAN_OUT = 3;
  localparam int IDX_W   = 2;

  logic clk = 1'b0;
  logic rst;
  logic forward;

  always #5 clk = ~clk;

  fc_accumulator_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  fc_accumulator #(
    .DATA_W(DATA_W), .FRAC(FRAC), .ACC_W(ACC_W), .FAN_IN(FAN_IN), .FAN_OUT(FAN_OUT)
  ) dut (
    .clk(clk), .rst(rst), .forward(forward), .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;

  always @(negedge clk) if (bus.valid_o === 1'b1) pulses++;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_i    = 1'b0;
    bus.act_i      = '0;
    bus.weight_i   = '0;
    bus.has_bias_i = 1'b0;
    bus.bias_i     = '0;
    bus.relu_en_i  = 1'b0;
  endtask

  task automatic term(input int a, input int w, input int b, input bit hb, input bit relu);
    bus.valid_i    = 1'b1;
    bus.act_i      = DATA_W'(a);
    bus.weight_i   = DATA_W'(w);
    bus.has_bias_i = hb;
    bus.bias_i     = DATA_W'(b);
    bus.relu_en_i  = relu;
    tick();
  endtask

  task automatic neuron(input int a, input int w, input int b, input bit relu, input bit gaps);
    for (int i = 0; i < FAN_IN; i++) begin
      term(a, w, (i == 0) ? b : 0, (i == 0), relu);
      idle();
      if (gaps && i < FAN_IN - 1) repeat (1 + i) tick();
    end
  endtask

  task automatic expect_result(input string tag, input int res, input int sat, input int idx, input int done);
    check({tag, ".lat1"}, bus.valid_o, 0);
    tick();
    check({tag, ".valid"}, bus.valid_o, 1);
    check({tag, ".result"}, bus.result_o, res);
    check({tag, ".sat"}, bus.sat_o, sat);
    check({tag, ".idx"}, bus.neuron_idx_o, idx);
    check({tag, ".done"}, bus.done_o, done);
    tick();
    check({tag, ".pulse_end"}, bus.valid_o, 0);
  endtask

  initial begin
    rst = 1'b1;
    forward = 1'b0;
    idle();
    repeat (2) tick();
    check("reset.valid", bus.valid_o, 0);
    check("reset.result", bus.result_o, 0);
    check("reset.idx", bus.neuron_idx_o, 0);
    check("reset.sat", bus.sat_o, 0);
    check("reset.done", bus.done_o, 0);
    rst = 1'b0;
    forward = 1'b1;
    tick();

    neuron(256, 512, 128, 1'b0, 1'b0);
    expect_result("basic", 2176, 0, 0, 0);
    neuron(256, 512, 128, 1'b0, 1'b1);
    expect_result("gaps", 2176, 0, 1, 0);
    neuron(256, -512, 128, 1'b1, 1'b0);
    expect_result("relu_on", 0, 0, 2, 1);
    neuron(256, -512, 128, 1'b0, 1'b0);
    expect_result("relu_off", -1920, 0, 0, 0);
    neuron(32767, 32767, 0, 1'b0, 1'b0);
    expect_result("sat_hi", 32767, 1, 1, 0);
    neuron(32767, -32768, 0, 1'b0, 1'b0);
    expect_result("sat_lo", -32768, 1, 2, 1);
    check("pulses.after_sat", pulses, 6);

    term(256, 512, 128, 1'b1, 1'b0);
    term(256, 512, 0, 1'b0, 1'b0);
    idle();
    forward = 1'b0;
    repeat (3) tick();
    forward = 1'b1;
    tick();
    check("switch.no_pulse", pulses, 6);
    neuron(256, 512, 128, 1'b0, 1'b0);
    expect_result("after_switch", 2176, 0, 0, 0);

    for (int i = 0; i < FAN_IN; i++) term(256, 512, (i == 0) ? 128 : 0, (i == 0), 1'b0);
    idle();
    forward = 1'b0;
    tick();
    check("stage1_flush.valid", bus.valid_o, 0);
    tick();
    forward = 1'b1;
    tick();
    check("stage1_flush.pulses", pulses, 7);
    neuron(256, 512, 128, 1'b0, 1'b0);
    expect_result("idx_cleared", 2176, 0, 0, 0);

    term(256, 512, 128, 1'b1, 1'b0);
    term(256, 512, 0, 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("midrst.pulses", pulses, 8);

    for (int t = 0; t < 4 * FAN_IN; t++) begin
      term(256, 512, (t % FAN_IN == 0) ? 128 : 0, (t % FAN_IN == 0), 1'b0);
      if (t == 4 || t == 8 || t == 12) begin
        check("b2b.valid", bus.valid_o, 1);
        check("b2b.result", bus.result_o, 2176);
        check("b2b.idx", bus.neuron_idx_o, t / FAN_IN - 1);
        check("b2b.done", bus.done_o, (t == 12) ? 1 : 0);
      end else begin
        check("b2b.idle", bus.valid_o, 0);
      end
    end
    idle();
    tick();
    check("b2b4.valid", bus.valid_o, 1);
    check("b2b4.idx", bus.neuron_idx_o, 0);
    check("b2b4.done", bus.done_o, 0);
    tick();
    check("b2b4.end", bus.valid_o, 0);
    check("pulses.total", pulses, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fc_accumulator.md
Name: fc_accumulator

Overview:
Datapath stage directly downstream of the FC address scheduler: consumes activation/weight pairs read at the scheduler's pointers, plus the bias word flagged by its has_bias strobe. Performs fixed-point MAC over FAN_IN terms per output neuron, adds the bias, applies optional ReLU and saturation, and emits one result per neuron. Active only in the forward pass. Inputs are flushed on a forward/backward mode switch.

Parameters:
DATA_W, 16, signed activation/weight/bias/result width
FRAC, 8, fractional bits (Q(DATA_W-FRAC).FRAC)
ACC_W, 40, signed accumulator width; must be >= 2*DATA_W-FRAC+clog2(FAN_IN)+1
FAN_IN, 64, terms per neuron (>=1)
FAN_OUT, 10, neurons per layer pass (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
forward  in  1  1 = forward pass; block accepts data only when high
valid_i  in  1  act_i/weight_i/has_bias_i/bias_i valid this cycle
act_i  in  DATA_W  signed activation
weight_i  in  DATA_W  signed weight
has_bias_i  in  1  bias_i valid and applies to the neuron whose first term is this cycle
bias_i  in  DATA_W  signed bias, same Q format
relu_en_i  in  1  apply ReLU to result (sampled with the last term)
valid_o  out  1  one-cycle pulse, result_o valid
result_o  out  DATA_W  saturated (and optionally rectified) neuron output
neuron_idx_o  out  clog2(FAN_OUT)  index of neuron in result_o
sat_o  out  1  pulse with valid_o if saturation clipped result
done_o  out  1  pulse with valid_o when neuron_idx_o == FAN_OUT-1

Behaviour:
- Reset: valid_o, sat_o, done_o, result_o, neuron_idx_o = 0; term counter, neuron counter, pipeline valids, accumulator = 0; prev_forward = 0.
- Accept: a term is accepted when valid_i && forward && !mode_switch; mode_switch = forward ^ prev_forward (prev_forward registered every cycle).
- Term counter 0..FAN_IN-1 increments per accepted term and wraps to 0. first = (cnt==0); last = (cnt==FAN_IN-1). FAN_IN=1: first and last on every term.
- Stage 1 (edge after accept): p = (act_i*weight_i) as signed 2*DATA_W, arithmetic shift right FRAC (truncate toward -inf), sign-extend to ACC_W. Register p, first, last, bias_add = first && has_bias_i, bias sign-extended, relu_en_i, valid.
- has_bias_i on a non-first term is ignored. A first term without has_bias_i gets no bias.
- Stage 2: sum = (first ? (bias_add ? bias : 0) : acc) + p, in ACC_W with wrap-around. acc <= sum.
- If last: r = relu ? max(sum,0) : sum. result_o = clip(r, -2^(DATA_W-1), 2^(DATA_W-1)-1). sat_o = (clip changed r). Assert valid_o. neuron_idx_o = neuron counter. done_o = (counter==FAN_OUT-1). Then the neuron counter increments, wrapping to 0 after FAN_OUT-1.
- Latency: valid_o is exactly 2 cycles after the accepted last term. Bubbles (valid_i low) hold the counter and acc and do not corrupt the result.
- Back-to-back neurons at full rate: no gap is required between the last term of one neuron and the first term of the next.
- valid_o, sat_o, done_o are low on every cycle without a completing last term. result_o holds its last value.
- Mode switch: on any cycle with mode_switch=1, the following are cleared:
  - term counter, neuron counter, stage-1 valid, stage-2 output valid for that edge;
  - the partial acc is discarded.
  No valid_o results from terms accepted before the switch if their neuron was incomplete. A neuron whose last term is in stage 1 at the switch is also discarded.
- forward low: inputs ignored, outputs idle.
- rst mid-neuron: same as reset values; next accepted term is first of neuron 0.

Test Plan:
1. FAN_IN=4, FRAC=8: 4 consecutive terms act=256, weight=512; first term has_bias_i=1, bias=128 -> valid_o 2 cycles after 4th term, result_o=2176, neuron_idx_o=0, sat_o=0.
2. Same stimulus with 1-3 cycle valid_i gaps between terms -> result_o=2176, valid_o 2 cycles after last accepted term, no spurious pulses.
3. weight=-512, bias=128 -> sum -1920. relu_en_i=1 -> result_o=0, sat_o=0. relu_en_i=0 -> result_o=-1920.
4. act=weight=32767 x4 -> result_o=32767, sat_o=1. act=32767, weight=-32768 x4 -> result_o=-32768, sat_o=1.
5. FAN_IN=4: 2 terms accepted, forward drops 3 cycles, rises -> no valid_o. Then 4 fresh terms as test 1 -> result_o=2176, neuron_idx_o=0.
6. FAN_OUT=3, 3 neurons back-to-back at full rate -> valid_o every 4 cycles, neuron_idx_o 0,1,2, done_o only with idx 2. A 4th neuron gets idx 0.
